// File: rtl/t07_mmio_bus_ctrl.sv
// t07_mmio_bus_ctrl: bus-side stage behind the CPU memory handler.
// Each handler request (read, write, instruction fetch) becomes exactly one
// Wishbone-style single transfer. busy_o frames the whole transaction, and its
// falling edge tells the handler to advance. Sub-word stores are replicated
// onto byte lanes. Sub-word loads are right-justified and zero-filled.
module t07_mmio_bus_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  rwi_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUS   = 2'd1,
      S_FAULT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] RWI_IDLE  = 2'b00;
   localparam logic [1:0] RWI_WRITE = 2'b01;
   localparam logic [1:0] RWI_FETCH = 2'b11;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // The counter is 8 bits wide, which covers the full 1..255 timeout range.
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic        is_rd_q, is_rd_d;     // read or fetch: the result lands in rdata_o
   logic [1:0]  size_q, size_d;       // effective size, already resolved to byte/half/word
   logic [1:0]  ofs_q, ofs_d;         // byte offset within the word
   logic [7:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;

   logic [1:0]  req_size;
   logic        req_misaligned;

   // A fetch always moves a word. The unused encoding 11 is treated as a word.
   function automatic logic [1:0] eff_size(input logic [1:0] rwi, input logic [1:0] size);
      if (rwi == RWI_FETCH || size == 2'b11) return SZ_WORD;
      return size;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
      case (size)
         SZ_HALF: return ofs[0];
         SZ_WORD: return (ofs != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] ofs);
      case (size)
         SZ_BYTE: return 4'b0001 << ofs;
         SZ_HALF: return 4'b0011 << ofs;
         default: return 4'b1111;
      endcase
   endfunction

   // The store value is replicated so that whichever lanes are enabled carry it.
   function automatic logic [31:0] lane_dat(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         SZ_BYTE: return {4{wd[7:0]}};
         SZ_HALF: return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] read_align(input logic [1:0] size, input logic [1:0] ofs,
                                              input logic [31:0] d);
      logic [31:0] s;
      s = d >> {ofs, 3'b000};
      case (size)
         SZ_BYTE: return {24'h0, s[7:0]};
         SZ_HALF: return {16'h0, s[15:0]};
         default: return s;
      endcase
   endfunction

   assign req_size       = eff_size(rwi_i, size_i);
   assign req_misaligned = is_misaligned(req_size, addr_i[1:0]);

   // Next-state and next-output logic; every register holds unless a state changes it.
   always_comb begin
      state_d = state_q;
      is_rd_d = is_rd_q;
      size_d  = size_q;
      ofs_d   = ofs_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;

      case (state_q)
         S_IDLE: begin
            if (rwi_i != RWI_IDLE) begin
               is_rd_d = rwi_i[1];
               size_d  = req_size;
               ofs_d   = addr_i[1:0];
               cnt_d   = 8'd0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               if (req_misaligned) begin
                  state_d = S_FAULT;
               end else begin
                  state_d = S_BUS;
                  cyc_d   = 1'b1;
                  we_d    = (rwi_i == RWI_WRITE);
                  adr_d   = {addr_i[31:2], 2'b00};
                  if (rwi_i == RWI_WRITE) begin
                     sel_d = lane_sel(req_size, addr_i[1:0]);
                     dat_d = lane_dat(req_size, wdata_i);
                  end else begin
                     sel_d = 4'hF;
                  end
               end
            end
         end

         S_BUS: begin
            if (wb_ack_i) begin
               // An ack wins even on the cycle that would otherwise time out.
               state_d = S_DONE;
               busy_d  = 1'b0;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               if (is_rd_q) rdata_d = read_align(size_q, ofs_q, wb_dat_i);
            end else if (cnt_q + 8'd1 == TO_LIMIT) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               err_d   = 1'b1;
               if (is_rd_q) rdata_d = ERR_DATA;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_FAULT: begin
            // Fault costs one busy cycle so the handler still sees a busy pulse.
            state_d = S_DONE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            if (is_rd_q) rdata_d = ERR_DATA;
         end

         default: begin
            // DONE: one idle cycle so a request held by the handler is not re-issued.
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; the async reset also drops an in-flight bus cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         is_rd_q <= 1'b0;
         size_q  <= SZ_BYTE;
         ofs_q   <= 2'b00;
         cnt_q   <= 8'd0;
         busy_q  <= 1'b0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 32'h0;
         dat_q   <= 32'h0;
         sel_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         is_rd_q <= is_rd_d;
         size_q  <= size_d;
         ofs_q   <= ofs_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
      end
   end

   assign busy_o   = busy_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_t07_mmio_bus_ctrl.sv
// Directed bench for t07_mmio_bus_ctrl with a small expected-result scoreboard.
module tb_t07_mmio_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rwi_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          busy_n;
      int          bus_n;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
   } exp_t;

   exp_t sb[$];

   t07_mmio_bus_ctrl #(
      .TIMEOUT_CYCLES(4),
      .ERR_DATA      (32'hBAD0_BAD0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rwi_i   (rwi_i),
      .size_i  (size_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .busy_o  (busy_o),
      .rdata_o (rdata_o),
      .err_o   (err_o),
      .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o),
      .wb_we_o (wb_we_o),
      .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o),
      .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request and let the bus model ack in BUS cycle ack_at (0 = never).
   task automatic run_txn(input string tag, input logic [1:0] rwi, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] bus_rd, input logic hold,
                          input logic [31:0] e_rd, input logic e_err,
                          input int e_busy, input int e_bus,
                          input logic [31:0] e_adr, input logic [31:0] e_dat,
                          input logic [3:0] e_sel, input logic e_we);
      exp_t e;
      exp_t got;
      int nbusy;
      int nbus;
      e.tag = tag;   e.rdata = e_rd;  e.err = e_err;
      e.busy_n = e_busy; e.bus_n = e_bus;
      e.adr = e_adr; e.dat = e_dat; e.sel = e_sel; e.we = e_we;
      sb.push_back(e);

      rwi_i = rwi; size_i = sz; addr_i = addr; wdata_i = wd; wb_dat_i = bus_rd;
      @(negedge clk);
      chk({tag, ".busy_rise"}, 32'(busy_o), 32'd1);
      if (!hold) rwi_i = 2'b00;
      nbusy = 0;
      nbus  = 0;
      while (busy_o === 1'b1 && nbusy < 40) begin
         nbusy++;
         if (wb_cyc_o === 1'b1) begin
            nbus++;
            if (nbus == 1) begin
               chk({tag, ".adr"}, wb_adr_o, sb[0].adr);
               chk({tag, ".sel"}, 32'(wb_sel_o), 32'(sb[0].sel));
               chk({tag, ".we"},  32'(wb_we_o), 32'(sb[0].we));
               chk({tag, ".stb"}, 32'(wb_stb_o), 32'd1);
               if (sb[0].we) chk({tag, ".dat"}, wb_dat_o, sb[0].dat);
            end
         end
         wb_ack_i = (wb_cyc_o === 1'b1) && (nbus == ack_at);
         @(negedge clk);
      end
      wb_ack_i = 1'b0;
      chk({tag, ".busy_bounded"}, 32'(nbusy < 40), 32'd1);

      got = sb.pop_front();
      chk({got.tag, ".rdata"},  rdata_o, got.rdata);
      chk({got.tag, ".err"},    32'(err_o), 32'(got.err));
      chk({got.tag, ".busy_n"}, nbusy, got.busy_n);
      chk({got.tag, ".bus_n"},  nbus, got.bus_n);
      chk({got.tag, ".cyc_end"}, 32'(wb_cyc_o), 32'd0);

      // The DONE cycle passes here; a held request must not start a second transfer.
      @(negedge clk);
      rwi_i = 2'b00;
      chk({tag, ".no_reissue"}, 32'(busy_o | wb_cyc_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      rwi_i = 2'b00; size_i = 2'b00; addr_i = 32'h0; wdata_i = 32'h0;
      wb_dat_i = 32'h0; wb_ack_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst.busy",  32'(busy_o), 32'd0);
      chk("rst.rdata", rdata_o, 32'h0);
      chk("rst.err",   32'(err_o), 32'd0);
      chk("rst.cyc",   32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
      chk("rst.adr",   wb_adr_o, 32'h0);
      chk("rst.dat",   wb_dat_o, 32'h0);
      chk("rst.sel",   32'(wb_sel_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      //      tag          rwi    sz     addr          wdata         ack bus_rd        hold  e_rdata       err  bsy bus e_adr        e_dat         sel      we
      run_txn("fetch100",  2'b11, 2'b00, 32'h0000_0100, 32'h0,        3, 32'h0050_0093, 1'b0, 32'h0050_0093, 1'b0, 3, 3, 32'h0000_0100, 32'h0,        4'hF,    1'b0);
      run_txn("wr_b203",   2'b01, 2'b00, 32'h0000_0203, 32'h0000_00AB, 1, 32'hFFFF_FFFF, 1'b0, 32'h0050_0093, 1'b0, 1, 1, 32'h0000_0200, 32'hABAB_ABAB, 4'b1000, 1'b1);
      run_txn("wr_h002",   2'b01, 2'b01, 32'h0000_0002, 32'h1234_CAFE, 2, 32'h0,        1'b0, 32'h0050_0093, 1'b0, 2, 2, 32'h0000_0000, 32'hCAFE_CAFE, 4'b1100, 1'b1);
      run_txn("wr_w010",   2'b01, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0,        1'b0, 32'h0050_0093, 1'b0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    1'b1);
      run_txn("rd_h002",   2'b10, 2'b01, 32'h0000_0002, 32'h0,        1, 32'hBEEF_1234, 1'b0, 32'h0000_BEEF, 1'b0, 1, 1, 32'h0000_0000, 32'h0,        4'hF,    1'b0);
      run_txn("rd_b301",   2'b10, 2'b00, 32'h0000_0301, 32'h0,        1, 32'h1122_3344, 1'b0, 32'h0000_0033, 1'b0, 1, 1, 32'h0000_0300, 32'h0,        4'hF,    1'b0);
      run_txn("rd_w006",   2'b10, 2'b10, 32'h0000_0006, 32'h0,        1, 32'h1111_1111, 1'b0, 32'hBAD0_BAD0, 1'b1, 1, 0, 32'h0,        32'h0,        4'hF,    1'b0);
      run_txn("rd_w008",   2'b10, 2'b10, 32'h0000_0008, 32'h0,        1, 32'h7777_0001, 1'b0, 32'h7777_0001, 1'b0, 1, 1, 32'h0000_0008, 32'h0,        4'hF,    1'b0);
      run_txn("wr_h001",   2'b01, 2'b01, 32'h0000_0001, 32'h0000_5555, 1, 32'h0,        1'b0, 32'h7777_0001, 1'b1, 1, 0, 32'h0,        32'h0,        4'hF,    1'b0);
      run_txn("rd_tmo",    2'b10, 2'b10, 32'h0000_0010, 32'h0,        0, 32'h0,        1'b0, 32'hBAD0_BAD0, 1'b1, 4, 4, 32'h0000_0010, 32'h0,        4'hF,    1'b0);
      run_txn("rd_ack4",   2'b10, 2'b10, 32'h0000_0014, 32'h0,        4, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 4, 4, 32'h0000_0014, 32'h0,        4'hF,    1'b0);
      run_txn("fetch102",  2'b11, 2'b00, 32'h0000_0102, 32'h0,        1, 32'h0,        1'b0, 32'hBAD0_BAD0, 1'b1, 1, 0, 32'h0,        32'h0,        4'hF,    1'b0);
      run_txn("rd_hold",   2'b10, 2'b10, 32'h0000_0020, 32'h0,        2, 32'h55AA_55AA, 1'b1, 32'h55AA_55AA, 1'b0, 2, 2, 32'h0000_0020, 32'h0,        4'hF,    1'b0);
      run_txn("rd_sz11",   2'b10, 2'b11, 32'h0000_0024, 32'h0,        1, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0, 1, 1, 32'h0000_0024, 32'h0,        4'hF,    1'b0);

      // Asynchronous reset in the middle of a bus cycle.
      rwi_i = 2'b11; size_i = 2'b10; addr_i = 32'h0000_0040;
      @(negedge clk);
      rwi_i = 2'b00;
      chk("arst.cyc_before", 32'(wb_cyc_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst.cyc",   32'(wb_cyc_o), 32'd0);
      chk("arst.busy",  32'(busy_o), 32'd0);
      chk("arst.rdata", rdata_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst.idle", 32'(busy_o | wb_cyc_o), 32'd0);
      run_txn("fetch040",  2'b11, 2'b01, 32'h0000_0040, 32'h0,        1, 32'h0000_0013, 1'b0, 32'h0000_0013, 1'b0, 1, 1, 32'h0000_0040, 32'h0,        4'hF,    1'b0);

      chk("sb.empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
